// File: rtl/kim_pkg.sv
// Shared types and widths for the KIM-1 bus arbitration slice.
package kim_pkg;

    localparam int unsigned KIM_AW = 16;
    localparam int unsigned KIM_DW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_RD = 2'd1,
        ACCESS  = 2'd2,
        CAPTURE = 2'd3
    } arb_state_t;

endpackage : kim_pkg

// File: rtl/kim_bus_arbiter.sv
// Lends the KIM-1 bus to a host debug/loader port for one byte at a time,
// stalling the 6502 via RDY only while it sits in a read cycle.
module kim_bus_arbiter
    import kim_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 8,
    parameter int unsigned WAIT_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [KIM_AW-1:0] cpu_ab,
    input  logic [KIM_DW-1:0] cpu_do,
    input  logic              cpu_we,
    output logic              cpu_rdy,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [KIM_AW-1:0] host_addr,
    input  logic [KIM_DW-1:0] host_wdata,
    output logic              host_ack,
    output logic              host_err,
    output logic [KIM_DW-1:0] host_rdata,
    output logic [KIM_AW-1:0] ab,
    output logic [KIM_DW-1:0] bus_do,
    output logic              we,
    input  logic [KIM_DW-1:0] di,
    output logic              host_owns
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    arb_state_t        state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [KIM_AW-1:0] addr_q, addr_d;
    logic [KIM_DW-1:0] wdata_q, wdata_d;
    logic              hwe_q, hwe_d;
    logic              rdy_d, ack_d, err_d, owns_d;
    logic [KIM_DW-1:0] rdata_d;

    // Bus mux: host cycle only while host_owns, CPU pass-through otherwise.
    assign ab     = host_owns ? addr_q  : cpu_ab;
    assign bus_do = host_owns ? wdata_q : cpu_do;
    assign we     = host_owns ? hwe_q   : cpu_we;

    // Next-state and next registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hwe_d   = hwe_q;
        rdy_d   = 1'b1;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        owns_d  = 1'b0;
        rdata_d = host_rdata;
        case (state_q)
            IDLE: begin
                if (host_req) begin
                    addr_d  = host_addr;
                    wdata_d = host_wdata;
                    hwe_d   = host_we;
                    cnt_d   = '0;
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                // A read cycle can be stretched by RDY; writes cannot.
                if (!cpu_we) begin
                    rdy_d   = 1'b0;
                    owns_d  = 1'b1;
                    state_d = ACCESS;
                end else if (cnt_q == WAIT_LAST) begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + WAIT_W'(1);
                end
            end
            ACCESS: begin
                rdy_d   = 1'b0;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // Memory output now reflects the host address; the CPU
                // address is being re-read for the resuming CPU.
                if (!hwe_q) begin
                    rdata_d = di;
                end
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            hwe_q      <= 1'b0;
            cpu_rdy    <= 1'b1;
            host_ack   <= 1'b0;
            host_err   <= 1'b0;
            host_rdata <= '0;
            host_owns  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hwe_q      <= hwe_d;
            cpu_rdy    <= rdy_d;
            host_ack   <= ack_d;
            host_err   <= err_d;
            host_rdata <= rdata_d;
            host_owns  <= owns_d;
        end
    end

endmodule : kim_bus_arbiter

// File: tb/tb_kim_bus_arbiter.sv
// Directed bench for kim_bus_arbiter with a registered 64K memory model.
module tb_kim_bus_arbiter;
    import kim_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [KIM_AW-1:0] cpu_ab;
    logic [KIM_DW-1:0] cpu_do;
    logic              cpu_we;
    logic              cpu_rdy;
    logic              host_req;
    logic              host_we;
    logic [KIM_AW-1:0] host_addr;
    logic [KIM_DW-1:0] host_wdata;
    logic              host_ack;
    logic              host_err;
    logic [KIM_DW-1:0] host_rdata;
    logic [KIM_AW-1:0] ab;
    logic [KIM_DW-1:0] bus_do;
    logic              we;
    logic [KIM_DW-1:0] di;
    logic              host_owns;

    logic [7:0] mem [0:65535];
    int n_chk = 0;
    int n_bad = 0;

    kim_bus_arbiter #(.WAIT_LIMIT(8), .WAIT_W(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_rdy(cpu_rdy),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_err(host_err),
        .host_rdata(host_rdata), .ab(ab), .bus_do(bus_do), .we(we),
        .di(di), .host_owns(host_owns)
    );

    always #5 clk = ~clk;

    // Registered memory: one-cycle read latency, write at clock edge.
    always @(posedge clk) begin
        if (we) mem[ab] <= bus_do;
        di <= mem[ab];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0200] = 8'h5A;
        mem[16'h0300] = 8'h11;
        mem[16'h1C00] = 8'hA5;
        mem[16'h1C01] = 8'hC3;
        reset = 1'b0; cpu_ab = 16'h0300; cpu_do = 8'h00; cpu_we = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        tick(); tick();
        reset = 1'b1;
        tick();
        check("rst_rdy", 32'(cpu_rdy), 32'd1);
        check("rst_ack", 32'(host_ack), 32'd0);
        check("rst_err", 32'(host_err), 32'd0);
        check("rst_rdata", 32'(host_rdata), 32'd0);
        check("rst_owns", 32'(host_owns), 32'd0);

        // 1: host read 0x0200 while CPU reads 0x0300
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0200;
        tick();                                   // E0: request sampled
        host_req = 1'b0;
        check("t1_wait_rdy", 32'(cpu_rdy), 32'd1);
        tick();                                   // E1: ACCESS
        check("t1_acc_rdy", 32'(cpu_rdy), 32'd0);
        check("t1_acc_owns", 32'(host_owns), 32'd1);
        check("t1_acc_ab", 32'(ab), 32'h0200);
        check("t1_acc_we", 32'(we), 32'd0);
        tick();                                   // E2: CAPTURE
        check("t1_cap_rdy", 32'(cpu_rdy), 32'd0);
        check("t1_cap_ab", 32'(ab), 32'h0300);
        tick();                                   // E3: ack
        check("t1_ack", 32'(host_ack), 32'd1);
        check("t1_err", 32'(host_err), 32'd0);
        check("t1_rdata", 32'(host_rdata), 32'h5A);
        check("t1_rdy_back", 32'(cpu_rdy), 32'd1);
        check("t1_cpu_di", 32'(di), 32'h11);
        tick();
        check("t1_ack_pulse", 32'(host_ack), 32'd0);
        check("t1_rdata_hold", 32'(host_rdata), 32'h5A);

        // 2: host write 0x17A0=0x3C during three stack writes
        cpu_we = 1'b1; cpu_ab = 16'h01FF; cpu_do = 8'h12;
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h17A0; host_wdata = 8'h3C;
        tick();                                   // E0
        host_req = 1'b0;
        cpu_ab = 16'h01FE; cpu_do = 8'h34;
        tick();                                   // E1: waiting
        check("t2_w1_rdy", 32'(cpu_rdy), 32'd1);
        check("t2_w1_owns", 32'(host_owns), 32'd0);
        cpu_ab = 16'h01FD; cpu_do = 8'h56;
        tick();                                   // E2: waiting
        check("t2_w2_rdy", 32'(cpu_rdy), 32'd1);
        cpu_we = 1'b0; cpu_ab = 16'hFFFE; cpu_do = 8'h00;
        tick();                                   // E3: ACCESS
        check("t2_acc_owns", 32'(host_owns), 32'd1);
        check("t2_acc_bus", {15'd0, we, ab}, {15'd0, 1'b1, 16'h17A0});
        check("t2_acc_do", 32'(bus_do), 32'h3C);
        tick();                                   // E4: CAPTURE, write landed
        tick();                                   // E5: ack
        check("t2_ack", 32'(host_ack), 32'd1);
        check("t2_err", 32'(host_err), 32'd0);
        check("t2_mem", 32'(mem[16'h17A0]), 32'h3C);
        check("t2_stack", {8'd0, mem[16'h01FF], mem[16'h01FE], mem[16'h01FD]}, 32'h00123456);
        check("t2_rdata_keep", 32'(host_rdata), 32'h5A);

        // 3: CPU stuck writing, host request times out
        tick();
        cpu_we = 1'b1; cpu_ab = 16'h0250; cpu_do = 8'h77;
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0280; host_wdata = 8'hEE;
        tick();                                   // E0
        host_req = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("t3_wait", {29'd0, host_ack, cpu_rdy, host_owns}, {29'd0, 3'b010});
        end
        tick();                                   // E8: abort
        check("t3_ack", 32'(host_ack), 32'd1);
        check("t3_err", 32'(host_err), 32'd1);
        check("t3_rdy", 32'(cpu_rdy), 32'd1);
        check("t3_rdata", 32'(host_rdata), 32'h5A);
        tick();
        check("t3_pulse", {30'd0, host_ack, host_err}, 32'd0);
        check("t3_no_write", 32'(mem[16'h0280]), 32'h00);
        cpu_we = 1'b0; cpu_ab = 16'h0300;

        // 4: reset during ACCESS
        tick();
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0200;
        tick();                                   // E0
        host_req = 1'b0;
        tick();                                   // E1: ACCESS
        check("t4_acc_owns", 32'(host_owns), 32'd1);
        reset = 1'b0;
        tick();
        check("t4_rst", {29'd0, cpu_rdy, host_owns, host_ack}, {29'd0, 3'b100});
        check("t4_bus", {15'd0, we, ab}, {15'd0, 1'b0, 16'h0300});
        reset = 1'b1;
        tick(); tick(); tick();
        check("t4_no_ack", {30'd0, host_ack, cpu_rdy}, {30'd0, 2'b01});

        // 5: back-to-back reads with host_req held
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h1C00;
        tick();                                   // E0
        tick(); tick();
        check("t5_pre_ack", 32'(host_ack), 32'd0);
        tick();                                   // E3
        check("t5_ack1", 32'(host_ack), 32'd1);
        check("t5_rdata1", 32'(host_rdata), 32'hA5);
        host_addr = 16'h1C01;
        tick();                                   // E4: idle sampled req
        check("t5_gap", 32'(host_ack), 32'd0);
        check("t5_gap_rdy", 32'(cpu_rdy), 32'd1);
        tick(); tick();
        check("t5_pre_ack2", 32'(host_ack), 32'd0);
        tick();                                   // E7
        check("t5_ack2", 32'(host_ack), 32'd1);
        check("t5_rdata2", 32'(host_rdata), 32'hC3);
        host_req = 1'b0;
        tick(); tick(); tick();

        // 6: idle host, random CPU traffic passes straight through
        for (int i = 0; i < 1000; i++) begin
            cpu_ab = 16'($urandom);
            cpu_do = 8'($urandom);
            cpu_we = 1'($urandom);
            #1;
            check("t6_pass", {7'd0, cpu_rdy, we, bus_do, ab},
                  {7'd0, 1'b1, cpu_we, cpu_do, cpu_ab});
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule : tb_kim_bus_arbiter
